// File: rtl/rf_wport_sched_if.sv
// rtl/rf_wport_sched_if.sv - bus bundle for the register-file write port scheduler
// Purpose: groups the WB, LU, scoreboard-query and regfile-write signals of
//          rf_wport_sched into one interface.
// Modports:
//   master - core side: drives WB/LU/issue/query inputs, observes grants/status
//   slave  - scheduler side: receives requests, drives rf_* and status outputs
interface rf_wport_sched_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            lu_issue;
  logic [4:0]      lu_issue_rd;
  logic            lu_issue_rdy;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            pipe_stall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            waw_err;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    output rs1_addr, rs2_addr,
    input  lu_issue_rdy, lu_ready, rs1_busy, rs2_busy,
    input  pipe_stall, rf_we, rf_waddr, rf_wdata, waw_err
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  lu_issue, lu_issue_rd, lu_valid, lu_rd, lu_data,
    input  rs1_addr, rs2_addr,
    output lu_issue_rdy, lu_ready, rs1_busy, rs2_busy,
    output pipe_stall, rf_we, rf_waddr, rf_wdata, waw_err
  );
endinterface

// File: rtl/rf_wport_sched.sv
// rtl/rf_wport_sched.sv - single regfile write port scheduler for WB and long-latency unit
// Purpose: arbitrates the regfile write port between in-order WB writes and a
//          1-entry hold register of LU results, keeps a busy scoreboard of
//          destinations with an LU result outstanding, and bounds LU starvation
//          by raising pipe_stall for one forced grant.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - rf_wport_sched_if.slave: WB request, LU issue/result handshakes,
//            rs1/rs2 busy queries, rf_we/rf_waddr/rf_wdata, pipe_stall, waw_err
module rf_wport_sched #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  rf_wport_sched_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic            hold_valid;
  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   wait_cnt;
  logic            pipe_stall;
  logic            waw_err;

  logic wb_wr;
  logic grant_h;
  logic grant_w;
  logic issue_acc;
  logic lu_acc;

  // A stalled pipeline's WB write is dropped; upstream replays it afterwards.
  assign wb_wr   = bus.wb_valid && (bus.wb_rd != 5'd0) && !pipe_stall;
  assign grant_h = hold_valid && (pipe_stall || !wb_wr);
  assign grant_w = !grant_h && wb_wr;

  assign bus.lu_issue_rdy = !busy[bus.lu_issue_rd] || (bus.lu_issue_rd == 5'd0);
  assign issue_acc        = bus.lu_issue && bus.lu_issue_rdy;

  // The hold entry frees up in the same cycle it is granted, so a new result
  // can be captured back-to-back.
  assign bus.lu_ready = !hold_valid || grant_h;
  assign lu_acc       = bus.lu_valid && bus.lu_ready;

  assign bus.rs1_busy   = busy[bus.rs1_addr];
  assign bus.rs2_busy   = busy[bus.rs2_addr];
  assign bus.pipe_stall = pipe_stall;
  assign bus.waw_err    = waw_err;

  // A held result for x0 still consumes its grant but never writes.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = '0;
    if (grant_h) begin
      bus.rf_we    = (hold_rd != 5'd0);
      bus.rf_waddr = hold_rd;
      bus.rf_wdata = hold_data;
    end else if (grant_w) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.wb_rd;
      bus.rf_wdata = bus.wb_data;
    end
  end

  // Clear first, then set, so a same-cycle re-issue of the drained rd keeps
  // its busy bit.
  always_comb begin
    busy_nxt = busy;
    if (grant_h) begin
      busy_nxt[hold_rd] = 1'b0;
    end
    if (issue_acc && (bus.lu_issue_rd != 5'd0)) begin
      busy_nxt[bus.lu_issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_rd    <= 5'd0;
      hold_data  <= '0;
      busy       <= '0;
      wait_cnt   <= '0;
      pipe_stall <= 1'b0;
      waw_err    <= 1'b0;
    end else begin
      busy <= busy_nxt;

      if (lu_acc) begin
        hold_valid <= 1'b1;
        hold_rd    <= bus.lu_rd;
        hold_data  <= bus.lu_data;
      end else if (grant_h) begin
        hold_valid <= 1'b0;
      end

      // While pipe_stall is high the hold is always granted, so this also
      // drops pipe_stall on the edge after the forced grant.
      if (hold_valid && !grant_h) begin
        wait_cnt   <= wait_cnt + 1'b1;
        pipe_stall <= (wait_cnt == CW'(STARVE_LIMIT - 1));
      end else begin
        wait_cnt   <= '0;
        pipe_stall <= 1'b0;
      end

      if (grant_w && busy[bus.wb_rd]) begin
        waw_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rf_wport_sched.sv
// tb/tb_rf_wport_sched.sv - directed self-checking bench for rf_wport_sched
module tb_rf_wport_sched;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rf_wport_sched_if #(.XLEN(32)) bus ();

  rf_wport_sched #(.XLEN(32), .NREG(32), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 32'd0;
    bus.lu_issue    = 1'b0;
    bus.lu_issue_rd = 5'd0;
    bus.lu_valid    = 1'b0;
    bus.lu_rd       = 5'd0;
    bus.lu_data     = 32'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_lu_ready", bus.lu_ready, 1'b1);
    chk("rst_stall", bus.pipe_stall, 1'b0);
    chk("rst_waw", bus.waw_err, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: plain WB write, same cycle
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hA5A5A5A5;
    #1;
    chk("t1_we", bus.rf_we, 1'b1);
    chk("t1_addr", bus.rf_waddr, 5'd5);
    chk("t1_data", bus.rf_wdata, 32'hA5A5A5A5);
    step();
    idle();

    // 2: issue rd=7, busy, re-issue refused, LU result drains it
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd7;
    #1;
    chk("t2_issue_rdy", bus.lu_issue_rdy, 1'b1);
    step();
    bus.lu_issue = 1'b0;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd6;
    #1;
    chk("t2_rs1_busy", bus.rs1_busy, 1'b1);
    chk("t2_rs2_busy", bus.rs2_busy, 1'b0);
    bus.lu_issue = 1'b1;
    #1;
    chk("t2_reissue_rdy", bus.lu_issue_rdy, 1'b0);
    bus.lu_issue = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h0000_0077;
    #1;
    chk("t2_lu_ready", bus.lu_ready, 1'b1);
    chk("t2_capture_we", bus.rf_we, 1'b0);
    step();
    idle();
    #1;
    chk("t2_hold_we", bus.rf_we, 1'b1);
    chk("t2_hold_addr", bus.rf_waddr, 5'd7);
    chk("t2_hold_data", bus.rf_wdata, 32'h0000_0077);
    chk("t2_busy_until_edge", bus.rs1_busy, 1'b1);
    step();
    chk("t2_busy_cleared", bus.rs1_busy, 1'b0);
    chk("t2_idle_we", bus.rf_we, 1'b0);

    // 3: starvation, WB busy every cycle
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd3; bus.lu_data = 32'h0000_0033;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h0000_0011;
    step();
    bus.lu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t3_wait%0d_stall", i), bus.pipe_stall, 1'b0);
      chk($sformatf("t3_wait%0d_addr", i), bus.rf_waddr, 5'd1);
      chk($sformatf("t3_wait%0d_lu_ready", i), bus.lu_ready, 1'b0);
      step();
    end
    chk("t3_stall_hi", bus.pipe_stall, 1'b1);
    chk("t3_stall_addr", bus.rf_waddr, 5'd3);
    chk("t3_stall_data", bus.rf_wdata, 32'h0000_0033);
    chk("t3_stall_we", bus.rf_we, 1'b1);
    step();
    chk("t3_stall_lo", bus.pipe_stall, 1'b0);
    chk("t3_wb_resume", bus.rf_waddr, 5'd1);
    idle();

    // 4: issue rd=9 in the cycle the held rd=9 is granted -> set wins
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h0000_0099;
    step();
    idle();
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd9;
    #1;
    chk("t4_issue_rdy", bus.lu_issue_rdy, 1'b1);
    chk("t4_grant_addr", bus.rf_waddr, 5'd9);
    step();
    idle();
    bus.rs1_addr = 5'd9;
    #1;
    chk("t4_busy9", bus.rs1_busy, 1'b1);

    // 5: x0 handling, held x0 drain, WAW error
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    chk("t5_wb_x0_we", bus.rf_we, 1'b0);
    idle();
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd0;
    #1;
    chk("t5_issue_x0_rdy", bus.lu_issue_rdy, 1'b1);
    step();
    bus.lu_issue = 1'b1;
    #1;
    chk("t5_x0_still_rdy", bus.lu_issue_rdy, 1'b1);
    idle();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h0000_0005;
    step();
    idle();
    #1;
    chk("t5_hold_x0_we", bus.rf_we, 1'b0);
    chk("t5_hold_x0_grant", bus.lu_ready, 1'b1);
    bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'd4;
    step();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h0000_0044;
    #1;
    chk("t5_waw_we", bus.rf_we, 1'b1);
    chk("t5_waw_pre", bus.waw_err, 1'b0);
    step();
    idle();
    #1;
    chk("t5_waw_set", bus.waw_err, 1'b1);
    step();
    step();
    chk("t5_waw_sticky", bus.waw_err, 1'b1);

    // 6: reset with hold valid and every busy bit set
    for (int r = 1; r < 32; r++) begin
      bus.lu_issue = 1'b1; bus.lu_issue_rd = 5'(r);
      step();
    end
    idle();
    bus.rs1_addr = 5'd31; bus.rs2_addr = 5'd1;
    #1;
    chk("t6_busy31", bus.rs1_busy, 1'b1);
    chk("t6_busy1", bus.rs2_busy, 1'b1);
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd12; bus.lu_data = 32'h0000_000C;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", bus.rf_we, 1'b0);
    chk("t6_rst_lu_ready", bus.lu_ready, 1'b1);
    chk("t6_rst_busy31", bus.rs1_busy, 1'b0);
    chk("t6_rst_busy1", bus.rs2_busy, 1'b0);
    chk("t6_rst_waw", bus.waw_err, 1'b0);
    chk("t6_rst_stall", bus.pipe_stall, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_we0", bus.rf_we, 1'b0);
    step();
    chk("t6_post_we1", bus.rf_we, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
